// File: rtl/control_sumador_serie.sv
// Multi-precision serial adder: one shared 4-bit ripple adder walks the
// operands one nibble per clock, LSB first, with the carry held in a register.

module sumador_4bits_ripple (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

module control_sumador_serie #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [3:0]       nib_sum;
    logic             nib_co;

    sumador_4bits_ripple u_sumador (
        .a  (opa[{idx, 2'b00} +: 4]),
        .b  (opb[{idx, 2'b00} +: 4]),
        .ci (carry),
        .s  (nib_sum),
        .co (nib_co)
    );

    // The last nibble's sum MSB is the result sign used for signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            S     <= '0;
            Co    <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        carry <= Ci;
                        S     <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    S[{idx, 2'b00} +: 4] <= nib_sum;
                    carry                <= nib_co;
                    if (idx == LAST) begin
                        idx   <= '0;
                        Co    <= nib_co;
                        ovf   <= (opa[WIDTH-1] == opb[WIDTH-1]) && (nib_sum[3] != opa[WIDTH-1]);
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
